regbank_dump_tx: RTL and testbench
==================================

# regbank_dump_tx

Debug readout engine for the register bank. On a start pulse it walks all 32 registers through one bank read port and transmits them as a UART 8N1 byte stream, preceded by a sync header. It sits beside the datapath, sharing a bank read port (muxed in by the top level while `busy` is high), and drives the board's debug TX pin.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2.
- `HEADER`, default 8'hA5: sync byte sent before the register data.

**Ports**
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: request a dump. Sampled on the rising edge. Ignored while `busy`.
- `readPort`, output, 5: register index presented to the bank read port.
- `busData`, input, 32: combinational read data from the bank for `readPort`.
- `tx`, output, 1: UART serial out. Idle level is high.
- `busy`, output, 1: high from start acceptance until the final stop bit completes.
- `done`, output, 1: one-cycle pulse when the dump completes.

## Operation

- **Reset values:** `tx`=1, `busy`=0, `done`=0, `readPort`=0, FSM=IDLE, all counters 0.
- **Frame:** HEADER, then registers 0..31 in order. Each register is sent as 4 bytes, little-endian ([7:0] first).
  - Total is 129 bytes.
  - Register 0 is sent as 00 00 00 00, because the bank returns 0 for index 0.
- **Byte format:** start bit 0, then data bits LSB-first, then stop bit 1. Each bit is held exactly `CLKS_PER_BIT` cycles.
- **FSM states:**
  - IDLE: `tx`=1. `start`=1 → HDR. Load shift register with HEADER; `busy`=1.
  - HDR: serialize the header byte. After the stop bit completes → LOAD with `readPort`=0.
  - LOAD: exactly one cycle, `tx`=1. At the end of the cycle, capture `busData` into the 32-bit word register. → SEND, byte index 0.
  - SEND: serialize byte [8*idx+7 : 8*idx] of the captured word. When a stop bit completes:
    - idx<3: idx+1 and stay in SEND.
    - idx=3 and `readPort`<31: `readPort`+1 → LOAD.
    - idx=3 and `readPort`=31: → IDLE, `busy`=0, `done`=1 for one cycle.
- **Counters:**
  - Baud counter runs 0..`CLKS_PER_BIT`-1 and wraps.
  - Bit counter runs 0..9.
  - Byte index runs 0..3.
  - `readPort` is 5 bits and never wraps past 31. The terminal check happens before increment.
- **Coherency:** each register is snapshotted at its own LOAD edge. The snapshot is not atomic across registers. CPU writes to an already-captured register are not reflected.
- **`start` handling:** `start` during `busy` is dropped, not queued. `start` held high at the `done` edge is not accepted. The IDLE check occurs on the next edge.
- **Reset mid-frame:** immediate abort. `tx` goes high asynchronously and no partial byte is completed.

## Timing

- Start accepted at edge E0. The header start bit is on `tx` from E0 until E0+C, where C=`CLKS_PER_BIT`.
- Byte n starts at E0 + 10·C·n + (number of LOAD cycles before it).
- The LOAD cycle adds one cycle of idle-high after the stop bit of the header and after every 4th data byte.
- Total busy duration: 129·10·C + 32 cycles. `done` asserts at edge E0 + 1290·C + 32. `busy` falls at the same edge.
- `readPort` changes only on the edge entering LOAD. `busData` must settle within that cycle (combinational bank read).
- `done` is never high while `busy` is high.

## Test plan

(Use C=4 for all scenarios.)

1. **Reset state.** Assert `rst` mid-cycle → `tx`=1, `busy`=0, `done`=0, `readPort`=0 immediately, without waiting for a clock edge.
2. **Full dump.** Bank preloaded with reg[r]=32'h01010101·r, plus r5=32'h12345678. Pulse `start`.
   - Decoded stream is A5, then 00 00 00 00, then 01 01 01 01, …
   - Bytes 21..24 are 78 56 34 12.
   - Total is 129 bytes.
   - `done` fires at cycle 1290·4+32 = 5192 after E0.
3. **Bit timing.** Header A5 on `tx`: 0, 1,0,1,0,0,1,0,1, 1. Each level holds exactly 4 cycles.
   - Idle-high gap after stop bit is exactly 1 cycle before register-0 start bit.
4. **Start while busy.** Pulse `start` at byte 50 → no restart, byte count stays 129, exactly one `done`.
   - A second `start` after `done` produces a fresh A5-led frame.
5. **Snapshot semantics.**
   - Write r3=DEADBEEF during byte 2 (before LOAD of r3) → r3 is sent as EF BE AD DE.
   - Write r1 during its SEND → the old value is sent.
6. **Reset mid-dump.** Assert `rst` during byte 70, release, then pulse `start` → `tx` goes high at once, and the new frame begins with A5 and `readPort`=0.

Source files
------------

// File: rtl/regbank_dump_tx.sv
// regbank_dump_tx: walks all 32 bank registers and streams them as UART 8N1 bytes behind a sync header
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             dump request (ignored while busy)
//   readPort/busData  bank read port index and its combinational read data
//   tx                UART serial out, idles high
//   busy, done        dump in progress / one-cycle completion pulse
module regbank_dump_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  readPort,
  input  logic [31:0] busData,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, HDR, LOAD, SEND} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    port_q, port_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic          bit_end;
  logic [7:0]    next_byte;
  assign bit_end   = baud_q == BW'(CLKS_PER_BIT - 1);
  // only consulted while idx_q < 3, so the 2-bit wrap of idx_q+1 never matters
  assign next_byte = 8'(word_q >> {idx_q + 2'd1, 3'd0});
  // tx_d always describes the level of the bit that starts at the coming edge,
  // so tx is a clean registered output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    port_d  = port_q;
    word_d  = word_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      tx_d = 1'b1;
      if (start) begin
        state_d = HDR;
        busy_d  = 1'b1;
        sh_d    = HEADER;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
      end
    end else if (state_q == LOAD) begin
      state_d = SEND;
      word_d  = busData;
      sh_d    = busData[7:0];
      idx_d   = '0;
      bit_d   = '0;
      baud_d  = '0;
      tx_d    = 1'b0;
    end else begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end) begin
        bit_d = bit_q + 4'd1;
        tx_d  = (bit_q == 4'd8) ? 1'b1 : sh_q[0];
        sh_d  = sh_q >> 1;
        if (bit_q == 4'd9) begin
          bit_d = '0;
          if (state_q == HDR) begin
            state_d = LOAD;
            port_d  = '0;
            tx_d    = 1'b1;
          end else if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            sh_d  = next_byte;
            tx_d  = 1'b0;
          end else if (port_q == 5'd31) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = LOAD;
            port_d  = port_q + 5'd1;
            tx_d    = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      port_q  <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      port_q  <= port_d;
      word_q  <= word_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign readPort = port_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_regbank_dump_tx.sv
// tb_regbank_dump_tx: scoreboard bench decoding the UART stream of regbank_dump_tx
module tb_regbank_dump_tx;
  localparam int C = 4;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [4:0]  readPort;
  logic [31:0] busData;
  logic        tx, busy, done;
  logic [31:0] bank [32];
  logic [31:0] snap [32];
  logic [7:0]  expq [$];
  int vecs = 0, errs = 0, cyc = 0, e0 = 0, nbytes = 0, ndone = 0;
  typedef struct { logic tx; logic busy; } vec_t;
  vec_t tv [42];
  assign busData = (readPort == 5'd0) ? 32'h0 : bank[readPort];
  regbank_dump_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .readPort(readPort),
    .busData(busData), .tx(tx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic       dbusy = 1'b0;
  int         k = 0;
  logic [7:0] dsh = 8'h0;
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      chk("done_while_busy", {31'd0, busy}, 32'd0);
    end
    if (rst) dbusy = 1'b0;
    else if (!dbusy) begin
      if (tx === 1'b0) begin
        dbusy = 1'b1;
        k = 0;
      end
    end else begin
      k++;
      if (k >= 5 && k <= 33 && (k % 4) == 1) dsh[(k - 5) / 4] = tx;
      if (k == 37) begin
        dbusy = 1'b0;
        chk($sformatf("stop_bit%0d", nbytes), {31'd0, tx}, 32'd1);
        if (expq.size() == 0) chk($sformatf("extra_byte%0d", nbytes), {24'd0, dsh}, 32'hFFFF_FFFF);
        else chk($sformatf("byte%0d", nbytes), {24'd0, dsh}, {24'd0, expq.pop_front()});
        nbytes++;
      end
    end
  end
  task automatic push_frame();
    logic [31:0] v;
    expq.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      v = (r == 0) ? 32'h0 : snap[r];
      for (int b = 0; b < 4; b++) expq.push_back(v[8*b +: 8]);
    end
  endtask
  task automatic arm();
    for (int r = 0; r < 32; r++) snap[r] = bank[r];
    nbytes = 0;
    ndone = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask
  task automatic wait_bytes(input int n);
    for (int t = 0; t < 20000 && nbytes < n; t++) @(negedge clk);
    chk("wait_bytes", {31'd0, nbytes >= n}, 32'd1);
  endtask
  task automatic wait_done();
    for (int t = 0; t < 6000 && !done; t++) @(negedge clk);
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("done_cycle", cyc - e0, 32'd5192);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    repeat (50) @(negedge clk);
    chk("byte_count", nbytes, 32'd129);
    chk("queue_empty", expq.size(), 32'd0);
    chk("done_count", ndone, 32'd1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_port"}, {27'd0, readPort}, 32'd0);
  endtask
  initial begin
    logic [9:0] hdr_bits;
    hdr_bits = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) tv[i] = '{hdr_bits[i / C], 1'b1};
    tv[40] = '{1'b1, 1'b1};
    tv[41] = '{1'b0, 1'b1};
    for (int r = 0; r < 32; r++) bank[r] = 32'h01010101 * r;
    bank[5] = 32'h12345678;
    #2 rst = 1'b1;
    #1 chk_reset("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    arm();
    push_frame();
    pulse_start();
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      chk($sformatf("tx_t%0d", i), {31'd0, tx}, {31'd0, tv[i].tx});
      chk($sformatf("busy_t%0d", i), {31'd0, busy}, {31'd0, tv[i].busy});
    end
    wait_done();
    arm();
    push_frame();
    pulse_start();
    wait_bytes(50);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    arm();
    snap[3] = 32'hDEADBEEF;
    push_frame();
    pulse_start();
    wait_bytes(2);
    bank[3] = 32'hDEADBEEF;
    wait_bytes(6);
    bank[1] = 32'hCAFEF00D;
    wait_done();
    arm();
    push_frame();
    pulse_start();
    wait_bytes(70);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset("mid");
    expq.delete();
    @(negedge clk) rst = 1'b0;
    arm();
    push_frame();
    pulse_start();
    @(negedge clk);
    chk("restart_tx", {31'd0, tx}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    repeat (40) @(negedge clk);
    chk("restart_gap_tx", {31'd0, tx}, 32'd1);
    chk("restart_port", {27'd0, readPort}, 32'd0);
    wait_done();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
